// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM states, default widths,
// the sequential PC increment and the NOP encoding.
package cpu_pkg;

    localparam int unsigned CPU_ADDR_W   = 64;
    localparam int unsigned CPU_INSTR_W  = 32;
    localparam int unsigned FETCH_PC_INC = 4;

    localparam logic [31:0] NOP_INSTR = 32'hD503201F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage (master)
// and the instruction memory (slave). One outstanding request, no pipelining.
interface if_fetch_stage_if #(
    parameter int unsigned ADDR_W  = cpu_pkg::CPU_ADDR_W,
    parameter int unsigned INSTR_W = cpu_pkg::CPU_INSTR_W
);

    logic               req;
    logic [ADDR_W-1:0]  addr;
    logic               ready;
    logic [INSTR_W-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  ready,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ready,
        output rdata
    );

endinterface

// File: rtl/if_skid_buf.sv
// One-entry skid buffer holding a fetched {instr, pc} while decode is stalled.
// Clear and unload both empty the entry; clear takes priority over load.
module if_skid_buf #(
    parameter int unsigned ADDR_W  = cpu_pkg::CPU_ADDR_W,
    parameter int unsigned INSTR_W = cpu_pkg::CPU_INSTR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               clear,
    input  logic               unload,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [ADDR_W-1:0]  in_pc,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc,
    output logic               full
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    // NOTE: the payload is reset as well as the flag; for a single entry this
    // keeps the outputs deterministic at negligible cost, unlike a RAM array.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full  <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (clear || unload) begin
            full <= 1'b0;
        end else if (load) begin
            full  <= 1'b1;
            instr <= in_instr;
            pc    <= in_pc;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC update, imem handshake, skid buffer, IF/ID register.
// Optional misaligned-redirect fault enabled by defining IF_ALIGN_CHECK_EN.
module if_fetch_stage
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W  = CPU_ADDR_W,
    parameter int unsigned INSTR_W = CPU_INSTR_W,
    parameter int unsigned PC_INC  = FETCH_PC_INC
) (
    input  logic               clk,
    input  logic               reset,

    input  logic [ADDR_W-1:0]  pc_in,
    output logic [ADDR_W-1:0]  next_pc,
    output logic               pc_write,

    if_fetch_stage_if.master   imem,

    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,

    output logic               ifid_valid,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc,
    output logic               fetch_fault
);

    localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

    fetch_state_t state, next_state;

    logic               ifid_from_mem;
    logic               ifid_from_skid;
    logic               ifid_bubble;
    logic               skid_load;
    logic               skid_clear;
    logic               misaligned;
    logic [INSTR_W-1:0] skid_instr;
    logic [ADDR_W-1:0]  skid_pc;
    logic               skid_full;

    if_skid_buf #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .load     (skid_load),
        .clear    (skid_clear),
        .unload   (ifid_from_skid),
        .in_instr (imem.rdata),
        .in_pc    (pc_in),
        .instr    (skid_instr),
        .pc       (skid_pc),
        .full     (skid_full)
    );

`ifdef IF_ALIGN_CHECK_EN
    assign misaligned = |branch_target[1:0];

    // Sticky until reset; parks the FSM in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_fault <= 1'b0;
        end else if (state != IDLE && branch_taken && misaligned) begin
            fetch_fault <= 1'b1;
        end
    end
`else
    assign misaligned  = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default first so no path
    // through the case statement can leave a signal unassigned (latch).
    always_comb begin
        next_state     = state;
        pc_write       = 1'b0;
        next_pc        = pc_in;
        imem.req       = (state == REQ);
        imem.addr      = pc_in;
        ifid_from_mem  = 1'b0;
        ifid_from_skid = 1'b0;
        ifid_bubble    = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;

        if (state != IDLE && branch_taken) begin
            // Redirect beats any response or stall: drop in-flight work.
            ifid_bubble = 1'b1;
            skid_clear  = 1'b1;
            if (misaligned) begin
                next_state = IDLE;
            end else begin
                pc_write   = 1'b1;
                next_pc    = branch_target;
                next_state = REQ;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (!fetch_fault) begin
                        next_state = REQ;
                    end
                end
                REQ: begin
                    if (imem.ready) begin
                        if (!stall) begin
                            pc_write      = 1'b1;
                            next_pc       = pc_in + INC;
                            ifid_from_mem = 1'b1;
                        end else begin
                            skid_load  = 1'b1;
                            next_state = HOLD;
                        end
                    end else if (!stall) begin
                        ifid_bubble = 1'b1;
                    end
                end
                HOLD: begin
                    // The PC register was not advanced on capture, so the
                    // successor is computed from the buffered PC.
                    if (!stall) begin
                        pc_write       = 1'b1;
                        next_pc        = skid_pc + INC;
                        ifid_from_skid = 1'b1;
                        next_state     = REQ;
                    end
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ifid_valid <= 1'b0;
            ifid_instr <= '0;
            ifid_pc    <= '0;
        end else if (ifid_bubble) begin
            ifid_valid <= 1'b0;
        end else if (ifid_from_mem) begin
            ifid_valid <= 1'b1;
            ifid_instr <= imem.rdata;
            ifid_pc    <= pc_in;
        end else if (ifid_from_skid && skid_full) begin
            ifid_valid <= 1'b1;
            ifid_instr <= skid_instr;
            ifid_pc    <= skid_pc;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios with literal
// expectations plus randomized traffic against a queue-based reference model.
module tb_if_fetch_stage;
    import cpu_pkg::*;

    localparam int AW = 64;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] pc_in = '0;
    logic [AW-1:0] next_pc;
    logic          pc_write;
    logic          stall = 1'b0;
    logic          branch_taken = 1'b0;
    logic [AW-1:0] branch_target = '0;
    logic          ifid_valid;
    logic [IW-1:0] ifid_instr;
    logic [AW-1:0] ifid_pc;
    logic          fetch_fault;

    if_fetch_stage_if #(.ADDR_W(AW), .INSTR_W(IW)) imem ();

    if_fetch_stage #(.ADDR_W(AW), .INSTR_W(IW), .PC_INC(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_in         (pc_in),
        .next_pc       (next_pc),
        .pc_write      (pc_write),
        .imem          (imem),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .ifid_valid    (ifid_valid),
        .ifid_instr    (ifid_instr),
        .ifid_pc       (ifid_pc),
        .fetch_fault   (fetch_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          valid;
        logic [IW-1:0] instr;
        logic [AW-1:0] pc;
    } ifid_t;

    typedef struct {
        logic [IW-1:0] instr;
        logic [AW-1:0] pc;
    } entry_t;

    typedef struct {
        logic          req;
        logic [AW-1:0] addr;
        logic          pw;
        logic [AW-1:0] np;
    } comb_t;

    int     tests = 0;
    int     fails = 0;
    bit     chk_en = 1'b1;
    bit     m_active = 1'b0;
    entry_t m_skid[$];
    ifid_t  m_ifid = '{1'b0, '0, '0};
    comb_t  last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected combinational outputs for the current inputs and model state.
    function automatic comb_t model_comb();
        comb_t c;
        c.req  = 1'b0;
        c.addr = pc_in;
        c.pw   = 1'b0;
        c.np   = pc_in;
        if (reset && m_active) begin
            c.req = (m_skid.size() == 0);
            if (branch_taken) begin
                c.pw = 1'b1;
                c.np = branch_target;
            end else if (m_skid.size() != 0) begin
                if (!stall) begin
                    c.pw = 1'b1;
                    c.np = m_skid[0].pc + 64'd4;
                end
            end else if (imem.ready && !stall) begin
                c.pw = 1'b1;
                c.np = pc_in + 64'd4;
            end
        end
        return c;
    endfunction

    // Reference model: a waiting-after-reset flag, a skid queue and the IF/ID entry.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active = 1'b0;
            m_skid.delete();
            m_ifid = '{1'b0, '0, '0};
        end else if (!m_active) begin
            m_active = 1'b1;
        end else if (branch_taken) begin
            m_skid.delete();
            m_ifid.valid = 1'b0;
        end else if (m_skid.size() != 0) begin
            if (!stall) begin
                m_ifid = '{1'b1, m_skid[0].instr, m_skid[0].pc};
                m_skid.delete();
            end
        end else if (imem.ready) begin
            if (!stall) m_ifid = '{1'b1, imem.rdata, pc_in};
            else        m_skid.push_back('{imem.rdata, pc_in});
        end else if (!stall) begin
            m_ifid.valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        comb_t c;
        if (chk_en) begin
            c = model_comb();
            check("cmp_imem_req", imem.req, c.req);
            if (c.req) check("cmp_imem_addr", imem.addr, c.addr);
            check("cmp_pc_write", pc_write, c.pw);
            if (c.pw) check("cmp_next_pc", next_pc, c.np);
            check("cmp_ifid_valid", ifid_valid, m_ifid.valid);
            if (m_ifid.valid) begin
                check("cmp_ifid_instr", ifid_instr, m_ifid.instr);
                check("cmp_ifid_pc", ifid_pc, m_ifid.pc);
            end
            check("cmp_fetch_fault", fetch_fault, 1'b0);
        end
    end

    task automatic settle();
        @(negedge clk);
        last = model_comb();
    endtask

    // PC register emulation driven by the model's expected write.
    task automatic advance();
        @(posedge clk);
        #1;
        if (last.pw) pc_in = last.np;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] tgt;
        int            r;
        imem.ready = 1'b0;
        imem.rdata = '0;
        pc_in      = 64'h1000;

        // Reset state
        settle();
        check("rst_imem_req", imem.req, 1'b0);
        check("rst_pc_write", pc_write, 1'b0);
        check("rst_ifid_valid", ifid_valid, 1'b0);
        check("rst_ifid_instr", ifid_instr, 32'h0);
        check("rst_ifid_pc", ifid_pc, 64'h0);
        check("rst_fetch_fault", fetch_fault, 1'b0);
        advance();
        advance();
        reset = 1'b1;

        // Sequential fetch at one instruction per cycle
        imem.ready = 1'b1;
        settle();
        check("idle_imem_req", imem.req, 1'b0);
        check("idle_pc_write", pc_write, 1'b0);
        advance();
        for (int k = 1; k <= 3; k++) begin
            imem.rdata = 32'h11110000 + 32'(k);
            settle();
            check("seq_pc_write", pc_write, 1'b1);
            check("seq_next_pc", next_pc, 64'h1000 + 64'(4 * k));
            if (k > 1) check("seq_ifid_pc", ifid_pc, 64'h1000 + 64'(4 * (k - 2)));
            advance();
        end

        // Memory wait states
        pc_in      = 64'h2000;
        imem.ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("wait_imem_req", imem.req, 1'b1);
            check("wait_imem_addr", imem.addr, 64'h2000);
            check("wait_pc_write", pc_write, 1'b0);
            if (k > 0) check("wait_ifid_valid", ifid_valid, 1'b0);
            advance();
        end
        imem.ready = 1'b1;
        imem.rdata = 32'h22220000;
        settle();
        check("wait_done_next_pc", next_pc, 64'h2004);
        advance();

        // Stall coincident with a response goes through the skid buffer
        pc_in      = 64'h3000;
        stall      = 1'b1;
        imem.rdata = NOP_INSTR;
        settle();
        check("stall_pc_write", pc_write, 1'b0);
        advance();
        imem.ready = 1'b0;
        imem.rdata = 32'hDEADBEEF;
        settle();
        check("hold_imem_req", imem.req, 1'b0);
        check("hold_ifid_pc", ifid_pc, 64'h2000);
        advance();
        stall = 1'b0;
        settle();
        check("unstall_pc_write", pc_write, 1'b1);
        check("unstall_next_pc", next_pc, 64'h3004);
        advance();
        settle();
        check("unstall_ifid_instr", ifid_instr, 32'hD503201F);
        check("unstall_ifid_pc", ifid_pc, 64'h3000);
        check("unstall_ifid_valid", ifid_valid, 1'b1);
        advance();

        // Branch redirect beats a same-cycle response
        imem.ready    = 1'b1;
        imem.rdata    = 32'hBAD0BAD0;
        branch_taken  = 1'b1;
        branch_target = 64'h4000;
        settle();
        check("br_next_pc", next_pc, 64'h4000);
        check("br_pc_write", pc_write, 1'b1);
        advance();
        branch_taken = 1'b0;
        imem.ready   = 1'b0;
        settle();
        check("br_ifid_valid", ifid_valid, 1'b0);
        check("br_imem_addr", imem.addr, 64'h4000);
        advance();

        // PC wrap-around at the top of the address space
        branch_taken  = 1'b1;
        branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
        settle();
        advance();
        branch_taken = 1'b0;
        imem.ready   = 1'b1;
        settle();
        check("wrap_next_pc", next_pc, 64'h0);
        advance();

        // Reset asserted while in HOLD
        stall = 1'b1;
        settle();
        advance();
        settle();
        check("hold2_imem_req", imem.req, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("rsthold_imem_req", imem.req, 1'b0);
        check("rsthold_pc_write", pc_write, 1'b0);
        check("rsthold_ifid_valid", ifid_valid, 1'b0);
        check("rsthold_skid_full", dut.u_skid.full, 1'b0);
        advance();
        reset = 1'b1;
        stall = 1'b0;
        settle();
        check("rel_idle_imem_req", imem.req, 1'b0);
        advance();
        settle();
        check("rel_req_imem_req", imem.req, 1'b1);
        advance();

        // Randomized traffic with a mid-run reset pulse
        for (int i = 0; i < 800; i++) begin
            reset        = (i != 400);
            imem.ready   = ($urandom_range(0, 3) != 0);
            stall        = ($urandom_range(0, 3) == 0);
            branch_taken = ($urandom_range(0, 15) == 0);
            r            = int'($urandom_range(0, 7));
            tgt          = {$urandom, $urandom};
            tgt[1:0]     = 2'b00;
            if (r == 0) tgt = 64'hFFFF_FFFF_FFFF_FFFC;
`ifndef IF_ALIGN_CHECK_EN
            if (r == 1) tgt[1:0] = 2'b10;
`endif
            branch_target = tgt;
            imem.rdata    = $urandom;
            settle();
            advance();
        end
        reset        = 1'b1;
        branch_taken = 1'b0;
        stall        = 1'b0;
        imem.ready   = 1'b0;
        settle();
        advance();
        settle();
        advance();

`ifdef IF_ALIGN_CHECK_EN
        // Misaligned redirect raises a sticky fault and stops fetching
        chk_en        = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 64'h4002;
        settle();
        check("mis_pc_write", pc_write, 1'b0);
        advance();
        branch_taken = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("mis_fetch_fault", fetch_fault, 1'b1);
            check("mis_imem_req", imem.req, 1'b0);
            advance();
        end
`else
        // Misaligned target is fetched as given
        branch_taken  = 1'b1;
        branch_target = 64'h4002;
        settle();
        check("mis_next_pc", next_pc, 64'h4002);
        advance();
        branch_taken = 1'b0;
        settle();
        check("mis_imem_addr", imem.addr, 64'h4002);
        check("mis_fetch_fault", fetch_fault, 1'b0);
        advance();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly downstream of the PC register. It consumes the current PC and produces the next PC plus that register's write enable.
- Issues instruction-memory requests with a req/ready handshake.
- Holds the fetched instruction across downstream stalls in a one-entry skid buffer.
- Drives the IF/ID pipeline register consumed by decode. Handles branch redirect and flush.

Parameters:
- ADDR_W, 64, PC and memory address width.
- INSTR_W, 32, instruction word width.
- PC_INC, 4, sequential PC increment in bytes.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- pc_in  input  ADDR_W  current PC from the PC register.
- next_pc  output  ADDR_W  value for the PC register to load.
- pc_write  output  1  PC register write enable; combinational, valid in the same cycle.
- imem_req  output  1  instruction-memory request valid.
- imem_addr  output  ADDR_W  request address.
- imem_ready  input  1  response valid; imem_rdata is valid this cycle.
- imem_rdata  input  INSTR_W  fetched instruction.
- stall  input  1  decode cannot accept a new IF/ID entry.
- branch_taken  input  1  redirect request from execute.
- branch_target  input  ADDR_W  redirect address.
- ifid_valid  output  1  IF/ID entry valid.
- ifid_instr  output  INSTR_W  IF/ID instruction.
- ifid_pc  output  ADDR_W  PC of ifid_instr.
- fetch_fault  output  1  misaligned-target fault (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; ifid_valid=0; ifid_instr=0; ifid_pc=0; skid empty; fetch_fault=0.
  - Combinational outputs imem_req=0 and pc_write=0 while in reset.
- FSM states: IDLE, REQ, HOLD.
- IDLE: one cycle after reset release, then go to REQ. No request is issued.
- REQ:
  - imem_req=1; imem_addr=pc_in.
  - imem_ready=1 and stall=0: pc_write=1, next_pc=pc_in+PC_INC. Next edge: ifid_valid=1, ifid_instr=imem_rdata, ifid_pc=pc_in. Stay in REQ.
  - imem_ready=1 and stall=1: capture rdata and pc_in into the skid buffer; pc_write=0; IF/ID holds its contents; go to HOLD.
  - imem_ready=0: pc_write=0; IF/ID holds if stall=1, otherwise ifid_valid<=0 (bubble).
- HOLD:
  - imem_req=0; IF/ID holds.
  - When stall=0: move the skid entry into IF/ID; pc_write=1, next_pc=skid_pc+PC_INC; go to REQ.
- Redirect, in any non-IDLE state:
  - branch_taken=1 wins over imem_ready and stall.
  - pc_write=1, next_pc=branch_target.
  - Any in-flight response is discarded; the skid buffer is cleared; ifid_valid<=0 next edge; go to REQ.
- Memory contract: imem_req stays asserted until imem_ready. Only one outstanding request; no pipelined responses.
- Sequential throughput: one instruction per cycle when imem_ready is held at 1 and stall=0.
- Arithmetic: PC increment is modulo 2^ADDR_W; wraps silently from all-ones minus 3 to 0.
- Reset asserted mid-request: the request drops immediately (combinational); the response is ignored after release.

Optional Feature:
- Macro: IF_ALIGN_CHECK_EN.
- Defined:
  - If branch_taken=1 and branch_target[1:0]!=0: pc_write=0, fetch_fault<=1 (sticky until reset), state goes to IDLE, ifid_valid<=0.
  - The FSM stays in IDLE while fetch_fault=1.
- Not defined: no check is made; fetch_fault is tied 0; misaligned targets are fetched as given.

Decomposition:
- Shared package cpu_pkg holds:
  - the fetch-state enum (IDLE, REQ, HOLD);
  - ADDR_W and INSTR_W defaults;
  - the PC_INC constant;
  - the NOP encoding.
- One natural sub-module: if_skid_buf, a one-entry {instr, pc, full} buffer with load, clear and unload controls.

Test Plan:
- Reset release, pc_in=0x1000, imem_ready=1 every cycle, stall=0 → pc_write on cycles 1,2,3 with next_pc 0x1004/0x1008/0x100C; ifid_pc follows one cycle later.
- imem_ready low for 3 cycles at pc_in=0x2000 → imem_req and imem_addr=0x2000 held; ifid_valid=0 for those cycles; pc_write=0.
- stall=1 in the same cycle as a response 0xD503201F at 0x3000 → HOLD with no pc_write; IF/ID unchanged. Stall released → ifid_instr=0xD503201F, ifid_pc=0x3000, next_pc=0x3004.
- branch_taken=1, target=0x4000, in the same cycle as imem_ready → next_pc=0x4000; response discarded; ifid_valid=0 next cycle; next request imem_addr=0x4000.
- Reset asserted while in HOLD → imem_req=0, ifid_valid=0 and skid empty immediately; after release, IDLE for one cycle, then REQ.
- With IF_ALIGN_CHECK_EN defined, branch_target=0x4002 → fetch_fault=1, pc_write=0, no further imem_req until reset.
